// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   XLEN_DEF     default address/data width
//   TIMEOUT_DEF  default REQ cycles allowed without mem_ready before abort
//   RISCV_NOP    value loaded into IR on reset and on any aborted fetch
//   fetch_state_t  2-bit fetch FSM state encoding
package instr_fetch_unit_pkg;

    localparam int          XLEN_DEF    = 32;
    localparam int          TIMEOUT_DEF = 16;
    localparam logic [31:0] RISCV_NOP   = 32'h0000_0013;  // addi x0, x0, 0

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read bus between the fetch unit and instruction memory.
//   req    fetch unit -> memory   read request, held until ready
//   addr   fetch unit -> memory   read address, stable while req=1
//   ready  memory -> fetch unit   rdata valid this cycle
//   rdata  memory -> fetch unit   fetched word
// master = fetch unit side, slave = memory side.
interface instr_fetch_unit_if
    import instr_fetch_unit_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
);
    logic            req;
    logic [XLEN-1:0] addr;
    logic            ready;
    logic [XLEN-1:0] rdata;

    modport master (output req, output addr, input ready, input rdata);
    modport slave  (input req, input addr, output ready, output rdata);
endinterface

// File: rtl/instr_fetch_unit_fetch_wait_counter.sv
// Wait counter for the fetch REQ phase.
//   clk, rst  clock, asynchronous active-high reset
//   clear     synchronous clear (new fetch accepted)
//   enable    count one REQ cycle that saw no mem_ready
//   tc        count has reached TIMEOUT_CYCLES-1 (next idle REQ cycle aborts)
module fetch_wait_counter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tc
);
    localparam int CW = $clog2(TIMEOUT_CYCLES);

    logic [CW-1:0] count;

    // The FSM stops enabling once tc is seen, so count never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         count <= '0;
        else if (clear)  count <= '0;
        else if (enable) count <= count + CW'(1);
    end

    assign tc = (count == CW'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: on fetch_start in IDLE, reads the word at pc_in
// over the memory bus, loads it into IR and captures pc_in+4.
//   clk, rst     clock, asynchronous active-high reset
//   fetch_start  one-cycle fetch command, accepted only in IDLE
//   pc_in        current PC
//   mem          instruction-memory bus (master side)
//   instr        instruction register
//   pc_plus4     captured pc_in + 4
//   fetch_done   one-cycle completion pulse (ok or error)
//   fetch_err    last fetch aborted; sticky until the next accepted start
//   busy         high in REQ and DONE
// Optional macro FETCH_MISALIGN_CHK_EN: a start with pc_in[1:0]!=0 skips the
// memory access and completes immediately with fetch_err=1 and IR=NOP.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int XLEN           = XLEN_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fetch_start,
    input  logic [XLEN-1:0]          pc_in,
    instr_fetch_unit_if.master       mem,
    output logic [XLEN-1:0]          instr,
    output logic [XLEN-1:0]          pc_plus4,
    output logic                     fetch_done,
    output logic                     fetch_err,
    output logic                     busy
);
    localparam logic [XLEN-1:0] NOP = XLEN'(RISCV_NOP);

    fetch_state_t    state_q, state_d;
    logic            req_q, req_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc4_q, pc4_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            busy_q, busy_d;
    logic            cnt_clr, cnt_en, cnt_tc;

    fetch_wait_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wait_cnt (
        .clk    (clk),
        .rst    (rst),
        .clear  (cnt_clr),
        .enable (cnt_en),
        .tc     (cnt_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
            instr_q <= NOP;
            pc4_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state and next-register values. fetch_done is registered, so it is
    // raised on the edge that enters DONE and lasts exactly the DONE cycle.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        err_d   = err_q;
        done_d  = 1'b0;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (fetch_start) begin
                    addr_d = pc_in;
                    pc4_d  = pc_in + XLEN'(4);
`ifdef FETCH_MISALIGN_CHK_EN
                    if (pc_in[1:0] != 2'b00) begin
                        instr_d = NOP;
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else
`endif
                    begin
                        err_d   = 1'b0;
                        cnt_clr = 1'b1;
                        req_d   = 1'b1;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                // ready wins over the timeout when both land on the same cycle
                if (mem.ready) begin
                    instr_d = mem.rdata;
                    req_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else if (cnt_tc) begin
                    instr_d = NOP;
                    err_d   = 1'b1;
                    req_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    assign mem.req    = req_q;
    assign mem.addr   = addr_q;
    assign instr      = instr_q;
    assign pc_plus4   = pc4_q;
    assign fetch_done = done_q;
    assign fetch_err  = err_q;
    assign busy       = busy_q;
endmodule
